// File: rtl/controlador_verificacao_codigo.sv
`default_nettype none
// ============================================================================
// Module   : controlador_verificacao_codigo
// Brief    : Sequential code-verification controller. Presents the stored
//            key (cmp_a) and the latched entry (cmp_b) to an external 3-bit
//            equality comparator, samples its FI flag, grants access or
//            counts failures, and enforces a timed lockout. Key
//            reprogramming is accepted only while access is granted.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_verificacao_codigo #(
  parameter int MAX_FAIL      = 3,
  parameter int LOCK_CYCLES   = 16,
  parameter int UNLOCK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  input  logic       prog_en,
  output logic       code_ready,
  output logic [2:0] cmp_a,
  output logic [2:0] cmp_b,
  input  logic       cmp_eq,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] fail_count,
  output logic       key_updated
);

  // Timer holds the larger of the two durations minus one.
  localparam int c_TMAX = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
  localparam int c_TW   = (c_TMAX > 2) ? $clog2(c_TMAX) : 1;

  localparam logic [c_TW-1:0] c_LOCK_LOAD   = c_TW'(LOCK_CYCLES - 1);
  localparam logic [c_TW-1:0] c_UNLOCK_LOAD = c_TW'(UNLOCK_CYCLES - 1);
  localparam logic [2:0]      c_MAX_FAIL3   = 3'(MAX_FAIL);
  localparam logic [1:0]      c_MAX_FAIL2   = 2'(MAX_FAIL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMP     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t          r_state;
  logic [2:0]      r_key;
  logic [2:0]      r_entry;
  logic [1:0]      r_fail_count;
  logic [c_TW-1:0] r_timer;
  logic            r_key_updated;
  logic [2:0]      w_fail_next;

  // Failure count after one more miss, widened so MAX_FAIL=3 cannot wrap.
  assign w_fail_next = {1'b0, r_fail_count} + 3'd1;

  // Main controller: state, key/entry registers, failure counter and timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_key         <= 3'b000;
      r_entry       <= 3'b000;
      r_fail_count  <= 2'd0;
      r_timer       <= '0;
      r_key_updated <= 1'b0;
    end else begin
      r_key_updated <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // prog_en has no meaning here; every submission is an attempt.
          if (code_valid) begin
            r_entry <= code_in;
            r_state <= ST_CMP;
          end
        end
        ST_CMP: begin
          if (cmp_eq) begin
            r_fail_count <= 2'd0;
            r_timer      <= c_UNLOCK_LOAD;
            r_state      <= ST_GRANT;
          end else if (w_fail_next == c_MAX_FAIL3) begin
            r_fail_count <= c_MAX_FAIL2;
            r_timer      <= c_LOCK_LOAD;
            r_state      <= ST_LOCKOUT;
          end else begin
            r_fail_count <= w_fail_next[1:0];
            r_state      <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // A key write wins over grant expiry on the same cycle.
          if (code_valid && prog_en) begin
            r_key         <= code_in;
            r_key_updated <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (r_timer == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (r_timer == '0) begin
            r_fail_count <= 2'd0;
            r_state      <= ST_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded directly from registered state.
  assign code_ready  = (r_state == ST_IDLE) || (r_state == ST_GRANT);
  assign unlocked    = (r_state == ST_GRANT);
  assign locked_out  = (r_state == ST_LOCKOUT);
  assign fail_count  = r_fail_count;
  assign key_updated = r_key_updated;
  assign cmp_a       = r_key;
  assign cmp_b       = r_entry;

endmodule
`default_nettype wire

// File: tb/tb_controlador_verificacao_codigo.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_verificacao_codigo
// Brief    : Self-checking bench for controlador_verificacao_codigo with a
//            behavioural 3-bit equality comparator in the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_verificacao_codigo;

  logic       clk;
  logic       rst_n;
  logic [2:0] code_in;
  logic       code_valid;
  logic       prog_en;
  logic       code_ready;
  logic [2:0] cmp_a;
  logic [2:0] cmp_b;
  logic       cmp_eq;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_count;
  logic       key_updated;

  int checks;
  int errors;

  controlador_verificacao_codigo #(
    .MAX_FAIL      (3),
    .LOCK_CYCLES   (16),
    .UNLOCK_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .prog_en     (prog_en),
    .code_ready  (code_ready),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_eq      (cmp_eq),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .fail_count  (fail_count),
    .key_updated (key_updated)
  );

  // External equality comparator (FI).
  assign cmp_eq = (cmp_a == cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] key;
    logic [2:0] entry;
    logic       exp_unlocked;
    logic [1:0] exp_fail;
  } vec_t;

  vec_t vecs[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_code_ready"},  32'(code_ready),  32'd1);
    check({tag, "_unlocked"},    32'(unlocked),    32'd0);
    check({tag, "_locked_out"},  32'(locked_out),  32'd0);
    check({tag, "_fail_count"},  32'(fail_count),  32'd0);
    check({tag, "_key_updated"}, 32'(key_updated), 32'd0);
    check({tag, "_cmp_a"},       32'(cmp_a),       32'd0);
    check({tag, "_cmp_b"},       32'(cmp_b),       32'd0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    code_valid = 1'b0;
    prog_en    = 1'b0;
    code_in    = 3'b000;
    step();
    rst_n = 1'b1;
  endtask

  // Submit an attempt from IDLE; returns after the result is visible.
  task automatic submit(input logic [2:0] code, input bit do_checks);
    code_in    = code;
    code_valid = 1'b1;
    prog_en    = 1'b0;
    step();
    code_valid = 1'b0;
    if (do_checks) begin
      check("cmp_ready_low", 32'(code_ready), 32'd0);
      check("cmp_not_unlocked", 32'(unlocked), 32'd0);
      check("cmp_b_latched", 32'(cmp_b), 32'(code));
      check("cmp_eq_known", 32'($isunknown(cmp_eq)), 32'd0);
    end
    step();
  endtask

  // Write a key while in GRANT.
  task automatic program_key(input logic [2:0] k);
    code_in    = k;
    code_valid = 1'b1;
    prog_en    = 1'b1;
    step();
    code_valid = 1'b0;
    prog_en    = 1'b0;
  endtask

  initial begin
    int cnt;
    checks = 0;
    errors = 0;

    for (int k = 0; k < 8; k++) begin
      for (int e = 0; e < 8; e++) begin
        vecs[k*8+e] = '{3'(k), 3'(e), (k == e), (k == e) ? 2'd0 : 2'd1};
      end
    end

    // Reset values.
    do_reset();
    check_reset_values("rst");

    // Submit 000 against reset key: grant lasts exactly 8 cycles.
    submit(3'b000, 1'b1);
    check("grant_cmp_a", 32'(cmp_a), 32'd0);
    check("grant_fail0", 32'(fail_count), 32'd0);
    check("grant_ready", 32'(code_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (unlocked) cnt++;
      if (unlocked && locked_out) check("exclusive", 32'd1, 32'd0);
      step();
    end
    check("grant_len", 32'(cnt), 32'd8);

    // Key write in GRANT.
    submit(3'b000, 1'b0);
    check("pre_write_unlocked", 32'(unlocked), 32'd1);
    program_key(3'b101);
    check("kw_pulse", 32'(key_updated), 32'd1);
    check("kw_cmp_a", 32'(cmp_a), 32'b101);
    check("kw_idle_unlocked", 32'(unlocked), 32'd0);
    check("kw_idle_ready", 32'(code_ready), 32'd1);
    step();
    check("kw_pulse_once", 32'(key_updated), 32'd0);
    submit(3'b101, 1'b1);
    check("new_key_unlocked", 32'(unlocked), 32'd1);
    // Non-programming strobe in GRANT is ignored.
    code_in = 3'b010; code_valid = 1'b1; prog_en = 1'b0;
    step();
    code_valid = 1'b0;
    check("grant_ignore_valid", 32'(unlocked), 32'd1);
    check("grant_ignore_key", 32'(cmp_a), 32'b101);
    for (int i = 0; i < 20 && unlocked; i++) step();
    submit(3'b000, 1'b1);
    check("wrong_fail1", 32'(fail_count), 32'd1);
    check("wrong_not_unl", 32'(unlocked), 32'd0);

    // Lockout sequence with key 101.
    do_reset();
    submit(3'b000, 1'b0);
    program_key(3'b101);
    step();
    submit(3'b110, 1'b0);
    check("lk_fail1", 32'(fail_count), 32'd1);
    submit(3'b011, 1'b0);
    check("lk_fail2", 32'(fail_count), 32'd2);
    submit(3'b111, 1'b0);
    check("lk_locked", 32'(locked_out), 32'd1);
    check("lk_fail_sat", 32'(fail_count), 32'd3);
    cnt = 0;
    code_in = 3'b101;
    for (int i = 0; i < 30; i++) begin
      if (locked_out) begin
        cnt++;
        if (code_ready !== 1'b0) check("lk_ready_low", 32'(code_ready), 32'd0);
        if (unlocked !== 1'b0) check("lk_exclusive", 32'(unlocked), 32'd0);
      end
      code_valid = locked_out;
      step();
    end
    code_valid = 1'b0;
    check("lk_len", 32'(cnt), 32'd16);
    check("lk_exit_fail0", 32'(fail_count), 32'd0);
    check("lk_entry_kept", 32'(cmp_b), 32'b111);
    check("lk_exit_ready", 32'(code_ready), 32'd1);

    // fail_count 2 then correct key clears it.
    submit(3'b000, 1'b0);
    submit(3'b001, 1'b0);
    check("fc2", 32'(fail_count), 32'd2);
    submit(3'b101, 1'b0);
    check("fc2_unlock", 32'(unlocked), 32'd1);
    check("fc2_cleared", 32'(fail_count), 32'd0);
    for (int i = 0; i < 20 && unlocked; i++) step();
    submit(3'b010, 1'b0);
    check("after_clear_fail1", 32'(fail_count), 32'd1);
    check("after_clear_no_lock", 32'(locked_out), 32'd0);

    // Reset during GRANT, with a key write presented on the reset edge.
    do_reset();
    submit(3'b000, 1'b0);
    program_key(3'b110);
    step();
    submit(3'b110, 1'b0);
    check("rg_in_grant", 32'(unlocked), 32'd1);
    rst_n = 1'b0; code_in = 3'b011; code_valid = 1'b1; prog_en = 1'b1;
    step();
    rst_n = 1'b1; code_valid = 1'b0; prog_en = 1'b0;
    check_reset_values("rst_grant");

    // Reset during LOCKOUT.
    submit(3'b001, 1'b0);
    submit(3'b001, 1'b0);
    submit(3'b001, 1'b0);
    check("rl_in_lock", 32'(locked_out), 32'd1);
    do_reset();
    check_reset_values("rst_lock");

    // Reset during CMP.
    code_in = 3'b011; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check("rc_in_cmp", 32'(code_ready), 32'd0);
    do_reset();
    check_reset_values("rst_cmp");

    // Exhaustive key x entry sweep.
    for (int v = 0; v < 64; v++) begin
      do_reset();
      submit(3'b000, 1'b0);
      program_key(vecs[v].key);
      step();
      submit(vecs[v].entry, 1'b0);
      check($sformatf("sw%0d_cmp_a", v), 32'(cmp_a), 32'(vecs[v].key));
      check($sformatf("sw%0d_cmp_b", v), 32'(cmp_b), 32'(vecs[v].entry));
      check($sformatf("sw%0d_unl", v), 32'(unlocked), 32'(vecs[v].exp_unlocked));
      check($sformatf("sw%0d_fail", v), 32'(fail_count), 32'(vecs[v].exp_fail));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
